// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock front panel: sequencer states,
// edit_field encodings, field widths/limits and modular field arithmetic.
package clock_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   localparam logic [4:0] HOUR_MAX    = 5'd23;
   localparam logic [5:0] MIN_SEC_MAX = 6'd59;

   typedef enum logic [2:0] {
      RUN    = 3'd0,
      EDIT_H = 3'd1,
      EDIT_M = 3'd2,
      EDIT_S = 3'd3,
      COMMIT = 3'd4
   } seq_state_t;

   localparam logic [1:0] FIELD_NONE = 2'd0;
   localparam logic [1:0] FIELD_HOUR = 2'd1;
   localparam logic [1:0] FIELD_MIN  = 2'd2;
   localparam logic [1:0] FIELD_SEC  = 2'd3;

   // Increment with wrap to zero past max_value.
   function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max_value);
      logic [5:0] res;
      if (value >= max_value) begin
         res = 6'd0;
      end else begin
         res = value + 6'd1;
      end
      return res;
   endfunction

   // Decrement with wrap from zero to max_value.
   function automatic logic [5:0] wrap_dec(input logic [5:0] value, input logic [5:0] max_value);
      logic [5:0] res;
      if (value == 6'd0) begin
         res = max_value;
      end else begin
         res = value - 6'd1;
      end
      return res;
   endfunction

   // True for the three field-editing states.
   function automatic logic is_edit(input seq_state_t st);
      logic res;
      case (st)
         EDIT_H, EDIT_M, EDIT_S: res = 1'b1;
         default:                res = 1'b0;
      endcase
      return res;
   endfunction

   // edit_field encoding shown to the display for a given state.
   function automatic logic [1:0] field_of(input seq_state_t st);
      logic [1:0] res;
      case (st)
         EDIT_H:  res = FIELD_HOUR;
         EDIT_M:  res = FIELD_MIN;
         EDIT_S:  res = FIELD_SEC;
         default: res = FIELD_NONE;
      endcase
      return res;
   endfunction

   // State reached on a MODE press from an editing state.
   function automatic seq_state_t mode_next(input seq_state_t st);
      seq_state_t res;
      case (st)
         EDIT_H:  res = EDIT_M;
         EDIT_M:  res = EDIT_S;
         EDIT_S:  res = COMMIT;
         default: res = RUN;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, debounce counter that restarts
// on any bounce, registered debounced level (released = 1) and a one-cycle
// press pulse on each accepted 1->0 transition.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_r;
   logic             sync2_r;
   logic             level_r;
   logic             press_r;
   logic [CNT_W-1:0] cnt_r;

   // Synchronize the raw key and accept a new level after a stable run.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         level_r <= 1'b1;
         press_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         sync1_r <= key_n;
         sync2_r <= sync1_r;
         if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
               level_r <= sync2_r;
               press_r <= ~sync2_r;
               cnt_r   <= {CNT_W{1'b0}};
            end else begin
               press_r <= 1'b0;
               cnt_r   <= cnt_r + CNT_W'(1);
            end
         end else begin
            press_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
         end
      end
   end

   assign level = level_r;
   assign press = press_r;

endmodule

// File: rtl/time_set_sequencer.sv
// Front-panel time-setting controller. Debounces MODE/INC/DEC, walks the
// hour/minute/second fields, freezes the clock core while editing and commits
// the shadow time with a single load strobe. Abandons an idle edit after
// TIMEOUT_TICKS seconds.
// Optional build macro TIME_SET_AUTOREPEAT_EN adds auto-repeat on held INC/DEC.
module time_set_sequencer
   import clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = 1000000,
   parameter int TIMEOUT_TICKS       = 30,
   parameter int REPEAT_DELAY_CYCLES = 25000000,
   parameter int REPEAT_RATE_CYCLES  = 5000000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              key_mode_n,
   input  logic              key_inc_n,
   input  logic              key_dec_n,
   input  logic              tick_1hz,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_minute,
   input  logic [SEC_W-1:0]  cur_second,
   output logic [HOUR_W-1:0] set_hour,
   output logic [MIN_W-1:0]  set_minute,
   output logic [SEC_W-1:0]  set_second,
   output logic              load_pulse,
   output logic              clock_enable,
   output logic [1:0]        edit_field,
   output logic              blink
);

   localparam int TO_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

   logic mode_press_s, inc_press_s, dec_press_s;
   logic mode_level_s, inc_level_s, dec_level_s;
   logic inc_rep_s, dec_rep_s;
   logic inc_ev_s, dec_ev_s, any_ev_s, step_inc_s, step_dec_s;
   logic in_edit_s;

   seq_state_t        state_r, state_nx;
   logic [HOUR_W-1:0] hour_r, hour_nx, hour_up_s, hour_dn_s;
   logic [MIN_W-1:0]  min_r, min_nx, min_up_s, min_dn_s;
   logic [SEC_W-1:0]  sec_r, sec_nx, sec_up_s, sec_dn_s;
   logic [TO_W-1:0]   to_cnt_r, to_cnt_nx;
   logic              load_pulse_r, clock_enable_r, blink_r;
   logic [1:0]        edit_field_r;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
      .clk(clk), .reset_n(reset_n), .key_n(key_mode_n), .level(mode_level_s), .press(mode_press_s)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
      .clk(clk), .reset_n(reset_n), .key_n(key_inc_n), .level(inc_level_s), .press(inc_press_s)
   );
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dec (
      .clk(clk), .reset_n(reset_n), .key_n(key_dec_n), .level(dec_level_s), .press(dec_press_s)
   );

   assign in_edit_s = is_edit(state_r);

`ifdef TIME_SET_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES
                                                                       : REPEAT_RATE_CYCLES;
   localparam int REP_W = $clog2(REP_MAX + 1);

   logic [1:0]       rep_held_s;
   logic [REP_W-1:0] rep_cnt_r [2];
   logic [1:0]       rep_first_r;
   logic [1:0]       rep_pulse_r;
   logic             unused_level_s;

   assign rep_held_s     = {~dec_level_s, ~inc_level_s};
   assign unused_level_s = mode_level_s;

   // Repeat timers: first step after the delay, then one per rate period while held.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            rep_cnt_r[i] <= {REP_W{1'b0}};
         end
         rep_first_r <= 2'b11;
         rep_pulse_r <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!rep_held_s[i] || !in_edit_s) begin
               rep_cnt_r[i]   <= {REP_W{1'b0}};
               rep_first_r[i] <= 1'b1;
               rep_pulse_r[i] <= 1'b0;
            end else if (rep_cnt_r[i] == (rep_first_r[i] ? REP_W'(REPEAT_DELAY_CYCLES - 1)
                                                          : REP_W'(REPEAT_RATE_CYCLES - 1))) begin
               rep_cnt_r[i]   <= {REP_W{1'b0}};
               rep_first_r[i] <= 1'b0;
               rep_pulse_r[i] <= 1'b1;
            end else begin
               rep_cnt_r[i]   <= rep_cnt_r[i] + REP_W'(1);
               rep_pulse_r[i] <= 1'b0;
            end
         end
      end
   end

   assign inc_rep_s = rep_pulse_r[0];
   assign dec_rep_s = rep_pulse_r[1];
`else
   logic unused_s;

   assign inc_rep_s = 1'b0;
   assign dec_rep_s = 1'b0;
   assign unused_s  = ^{mode_level_s, inc_level_s, dec_level_s, in_edit_s,
                        REPEAT_DELAY_CYCLES[0], REPEAT_RATE_CYCLES[0]};
`endif

   // Event arbitration: MODE beats a step, INC together with DEC cancels.
   assign inc_ev_s   = inc_press_s | inc_rep_s;
   assign dec_ev_s   = dec_press_s | dec_rep_s;
   assign any_ev_s   = mode_press_s | inc_ev_s | dec_ev_s;
   assign step_inc_s = inc_ev_s & ~dec_ev_s & ~mode_press_s;
   assign step_dec_s = dec_ev_s & ~inc_ev_s & ~mode_press_s;

   assign hour_up_s = HOUR_W'(wrap_inc({1'b0, hour_r}, {1'b0, HOUR_MAX}));
   assign hour_dn_s = HOUR_W'(wrap_dec({1'b0, hour_r}, {1'b0, HOUR_MAX}));
   assign min_up_s  = wrap_inc(min_r, MIN_SEC_MAX);
   assign min_dn_s  = wrap_dec(min_r, MIN_SEC_MAX);
   assign sec_up_s  = wrap_inc(sec_r, MIN_SEC_MAX);
   assign sec_dn_s  = wrap_dec(sec_r, MIN_SEC_MAX);

   // Next state, shadow time and idle-timeout count.
   always_comb begin
      state_nx  = state_r;
      hour_nx   = hour_r;
      min_nx    = min_r;
      sec_nx    = sec_r;
      to_cnt_nx = to_cnt_r;
      case (state_r)
         RUN: begin
            to_cnt_nx = {TO_W{1'b0}};
            if (mode_press_s) begin
               state_nx = EDIT_H;
               hour_nx  = cur_hour;
               min_nx   = cur_minute;
               sec_nx   = cur_second;
            end else begin
               state_nx = RUN;
            end
         end
         EDIT_H, EDIT_M, EDIT_S: begin
            if (mode_press_s) begin
               state_nx = mode_next(state_r);
            end else if (step_inc_s || step_dec_s) begin
               case (state_r)
                  EDIT_H:  hour_nx = step_inc_s ? hour_up_s : hour_dn_s;
                  EDIT_M:  min_nx  = step_inc_s ? min_up_s : min_dn_s;
                  EDIT_S:  sec_nx  = step_inc_s ? sec_up_s : sec_dn_s;
                  default: hour_nx = hour_r;
               endcase
            end else begin
               state_nx = state_r;
            end
            if (any_ev_s) begin
               to_cnt_nx = {TO_W{1'b0}};
            end else if (tick_1hz) begin
               if (to_cnt_r == TO_LAST) begin
                  state_nx  = RUN;
                  to_cnt_nx = {TO_W{1'b0}};
                  hour_nx   = {HOUR_W{1'b0}};
                  min_nx    = {MIN_W{1'b0}};
                  sec_nx    = {SEC_W{1'b0}};
               end else begin
                  to_cnt_nx = to_cnt_r + TO_W'(1);
               end
            end else begin
               to_cnt_nx = to_cnt_r;
            end
         end
         COMMIT: begin
            state_nx  = RUN;
            to_cnt_nx = {TO_W{1'b0}};
         end
         default: begin
            state_nx  = RUN;
            to_cnt_nx = {TO_W{1'b0}};
         end
      endcase
   end

   // State, shadow registers and registered outputs derived from the next state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r        <= RUN;
         hour_r         <= {HOUR_W{1'b0}};
         min_r          <= {MIN_W{1'b0}};
         sec_r          <= {SEC_W{1'b0}};
         to_cnt_r       <= {TO_W{1'b0}};
         load_pulse_r   <= 1'b0;
         clock_enable_r <= 1'b1;
         edit_field_r   <= FIELD_NONE;
         blink_r        <= 1'b0;
      end else begin
         state_r        <= state_nx;
         hour_r         <= hour_nx;
         min_r          <= min_nx;
         sec_r          <= sec_nx;
         to_cnt_r       <= to_cnt_nx;
         load_pulse_r   <= (state_nx == COMMIT);
         clock_enable_r <= (state_nx == RUN);
         edit_field_r   <= field_of(state_nx);
         blink_r        <= is_edit(state_nx) ? (blink_r ^ tick_1hz) : 1'b0;
      end
   end

   assign set_hour     = hour_r;
   assign set_minute   = min_r;
   assign set_second   = sec_r;
   assign load_pulse   = load_pulse_r;
   assign clock_enable = clock_enable_r;
   assign edit_field   = edit_field_r;
   assign blink        = blink_r;

endmodule

// File: tb/tb_time_set_sequencer.sv
// Directed bench for time_set_sequencer with short debounce/timeout settings.
// Expected committed times are queued when the edit is driven and popped
// when load_pulse is observed.
module tb_time_set_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       key_mode_n, key_inc_n, key_dec_n, tick_1hz;
   logic [4:0] cur_hour, set_hour;
   logic [5:0] cur_minute, cur_second, set_minute, set_second;
   logic       load_pulse, clock_enable, blink;
   logic [1:0] edit_field;

   int checks = 0;
   int errors = 0;
   int load_count = 0;
   int n;
   int exp_hour_rep;
   logic [16:0] exp_q[$];
   logic [16:0] exp_time;

   always #5 clk = ~clk;

   time_set_sequencer #(
      .DEBOUNCE_CYCLES(4), .TIMEOUT_TICKS(3),
      .REPEAT_DELAY_CYCLES(20), .REPEAT_RATE_CYCLES(5)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .key_mode_n(key_mode_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
      .tick_1hz(tick_1hz),
      .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
      .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
      .load_pulse(load_pulse), .clock_enable(clock_enable),
      .edit_field(edit_field), .blink(blink)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Press a key combination, hold it past debounce, release and let it settle.
   task automatic press(input logic m, input logic i, input logic d);
      @(posedge clk); #1;
      key_mode_n = ~m; key_inc_n = ~i; key_dec_n = ~d;
      repeat (8) @(posedge clk);
      #1;
      key_mode_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(posedge clk); #1 tick_1hz = 1'b1;
      @(posedge clk); #1 tick_1hz = 1'b0;
   endtask

   // Scoreboard side: every load must be expected and carry the queued time.
   always @(negedge clk) begin
      if (load_pulse === 1'b1) begin
         load_count++;
         check("load_expected", {31'd0, exp_q.size() > 0}, 32'd1);
         if (exp_q.size() > 0) begin
            exp_time = exp_q.pop_front();
            check("load_value", {15'd0, set_hour, set_minute, set_second}, {15'd0, exp_time});
         end
      end
   end

   initial begin
      reset_n = 1'b0; key_mode_n = 1'b1; key_inc_n = 1'b1; key_dec_n = 1'b1;
      tick_1hz = 1'b0; cur_hour = 5'd0; cur_minute = 6'd0; cur_second = 6'd0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      check("rst_clock_enable", clock_enable, 1);
      check("rst_edit_field", edit_field, 0);
      check("rst_load_pulse", load_pulse, 0);
      check("rst_set", {set_hour, set_minute, set_second}, 0);
      check("rst_blink", blink, 0);
      repeat (10) @(posedge clk);
      #1;
      check("idle_clock_enable", clock_enable, 1);
      check("idle_edit_field", edit_field, 0);

      // INC in RUN is ignored
      press(1'b0, 1'b1, 1'b0);
      check("run_inc_field", edit_field, 0);
      check("run_inc_hour", set_hour, 0);

      // Main edit flow 12:34:56 -> 14:33:56
      cur_hour = 5'd12; cur_minute = 6'd34; cur_second = 6'd56;
      press(1'b1, 1'b0, 1'b0);
      check("enter_field", edit_field, 1);
      check("enter_clock_enable", clock_enable, 0);
      check("enter_capture", {set_hour, set_minute, set_second}, {5'd12, 6'd34, 6'd56});
      press(1'b0, 1'b1, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      check("hour_inc2", set_hour, 14);
      press(1'b1, 1'b0, 1'b0);
      check("field_min", edit_field, 2);
      press(1'b0, 1'b0, 1'b1);
      check("min_dec", set_minute, 33);
      press(1'b1, 1'b0, 1'b0);
      check("field_sec", edit_field, 3);
      exp_q.push_back({5'd14, 6'd33, 6'd56});
      press(1'b1, 1'b0, 1'b0);
      check("commit_field", edit_field, 0);
      check("commit_clock_enable", clock_enable, 1);
      check("commit_loads", load_count, 1);

      // Wrap boundaries
      cur_hour = 5'd23; cur_minute = 6'd0; cur_second = 6'd59;
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      check("hour_wrap_up", set_hour, 0);
      press(1'b0, 1'b0, 1'b1);
      check("hour_wrap_down", set_hour, 23);
      press(1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1);
      check("min_wrap_down", set_minute, 59);
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      check("sec_wrap_up", set_second, 0);
      exp_q.push_back({5'd0, 6'd59, 6'd0});
      press(1'b1, 1'b0, 1'b0);
      check("wrap_loads", load_count, 2);

      // Simultaneous presses
      cur_hour = 5'd7; cur_minute = 6'd8; cur_second = 6'd9;
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b1);
      check("inc_dec_dropped", set_hour, 7);
      press(1'b1, 1'b1, 1'b0);
      check("mode_inc_field", edit_field, 2);
      check("mode_inc_hour", set_hour, 7);
      check("mode_inc_min", set_minute, 8);
      press(1'b1, 1'b0, 1'b0);
      exp_q.push_back({5'd7, 6'd8, 6'd9});
      press(1'b1, 1'b0, 1'b0);
      check("simul_loads", load_count, 3);

      // Bouncing MODE press, then idle timeout in EDIT_M
      cur_hour = 5'd1; cur_minute = 6'd2; cur_second = 6'd3;
      @(posedge clk); #1 key_mode_n = 1'b0;
      @(posedge clk); #1 key_mode_n = 1'b1;
      @(posedge clk); #1 key_mode_n = 1'b0;
      n = 0;
      while (n < 20 && edit_field !== 2'd1) begin
         @(posedge clk); #1;
         n++;
      end
      check("bounce_latency", {31'd0, (n >= 5) && (n <= 8)}, 1);
      repeat (10) @(posedge clk);
      #1 key_mode_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("bounce_single", edit_field, 1);
      press(1'b1, 1'b0, 1'b0);
      check("to_field_min", edit_field, 2);
      check("to_blink0", blink, 0);
      tick();
      check("to_blink1", blink, 1);
      tick();
      check("to_blink2", blink, 0);
      check("to_still_edit", edit_field, 2);
      tick();
      check("to_field", edit_field, 0);
      check("to_clock_enable", clock_enable, 1);
      check("to_blink_run", blink, 0);
      repeat (5) @(posedge clk);
      #1;
      check("to_no_load", load_count, 3);

      // Reset mid-edit
      cur_hour = 5'd9; cur_minute = 6'd9; cur_second = 6'd9;
      press(1'b1, 1'b0, 1'b0);
      check("mid_field", edit_field, 1);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_field", edit_field, 0);
      check("mid_rst_clock_enable", clock_enable, 1);
      check("mid_rst_set", {set_hour, set_minute, set_second}, 0);
      check("mid_rst_loads", load_count, 3);

      // Held INC: auto-repeat only in autorepeat builds
`ifdef TIME_SET_AUTOREPEAT_EN
      exp_hour_rep = 10;
`else
      exp_hour_rep = 6;
`endif
      cur_hour = 5'd5; cur_minute = 6'd10; cur_second = 6'd20;
      press(1'b1, 1'b0, 1'b0);
      @(posedge clk); #1 key_inc_n = 1'b0;
      n = 0;
      while (n < 20 && set_hour === 5'd5) begin
         @(posedge clk); #1;
         n++;
      end
      check("hold_first_step", set_hour, 6);
      repeat (32) @(posedge clk);
      #1 key_inc_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check("hold_steps", set_hour, exp_hour_rep);
      press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      exp_q.push_back({exp_hour_rep[4:0], 6'd10, 6'd20});
      press(1'b1, 1'b0, 1'b0);
      check("hold_loads", load_count, 4);
      check("sb_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
